// File: rtl/commit_arbiter.sv
// Two-requester front end for the single req/rsp channel of the commit DSP-instruction unit.
// One instruction in flight, round-robin on ties, and a response timeout that answers with an error.
module commit_arbiter #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned ERRW    = 8
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            m0_req_vaild,
  output logic            m0_req_ready,
  input  logic [31:0]     m0_r_in,
  output logic            m0_rsp_vaild,
  input  logic            m0_rsp_ready,
  output logic            m0_rsp_err,

  input  logic            m1_req_vaild,
  output logic            m1_req_ready,
  input  logic [31:0]     m1_r_in,
  output logic            m1_rsp_vaild,
  input  logic            m1_rsp_ready,
  output logic            m1_rsp_err,

  output logic            s_req_vaild,
  input  logic            s_req_ready,
  output logic [31:0]     s_r_in,
  input  logic            s_rsp_vaild,
  output logic            s_rsp_ready,

  output logic            busy,
  output logic            owner,
  output logic [ERRW-1:0] err_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StErr} state_e;

  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam logic [31:0] TimerLast = 32'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [31:0]       timer_q, timer_d;
  logic [ERRW-1:0]   err_cnt_q, err_cnt_d;

  logic              gnt_any;
  logic              gnt_idx;
  logic              own_rsp_ready;
  logic              own_rsp_vaild;
  logic              own_rsp_err;

  // On a tie the requester that was not served last wins.
  assign gnt_any       = m0_req_vaild | m1_req_vaild;
  assign gnt_idx       = (m0_req_vaild & m1_req_vaild) ? ~last_q : m1_req_vaild;
  assign own_rsp_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    owner_d       = owner_q;
    last_d        = last_q;
    timer_d       = timer_q;
    err_cnt_d     = err_cnt_q;
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    s_req_vaild   = 1'b0;
    s_r_in        = 32'h0;
    s_rsp_ready   = 1'b1;
    own_rsp_vaild = 1'b0;
    own_rsp_err   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gated by reset so nothing is accepted while the block is held in reset.
        m0_req_ready = reset & gnt_any & ~gnt_idx;
        m1_req_ready = reset & gnt_any & gnt_idx;
        if (gnt_any) begin
          instr_d = gnt_idx ? m1_r_in : m0_r_in;
          owner_d = gnt_idx;
          state_d = StIssue;
        end
      end

      StIssue: begin
        s_req_vaild = 1'b1;
        s_r_in      = instr_q;
        if (s_req_ready) begin
          timer_d = 32'h0;
          state_d = StWaitRsp;
        end
      end

      StWaitRsp: begin
        own_rsp_vaild = s_rsp_vaild;
        s_rsp_ready   = own_rsp_ready;
        if (s_rsp_vaild && own_rsp_ready) begin
          last_d  = owner_q;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 32'd1;
          // A handshake in the final cycle takes the branch above, so it beats the timeout.
          if (TimeoutEn && (timer_q == TimerLast)) begin
            state_d = StErr;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERRW'(1);
            end
          end
        end
      end

      StErr: begin
        own_rsp_vaild = 1'b1;
        own_rsp_err   = 1'b1;
        if (own_rsp_ready) begin
          last_d  = owner_q;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      instr_q   <= 32'h0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      timer_q   <= 32'h0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m0_rsp_vaild = own_rsp_vaild & ~owner_q;
  assign m1_rsp_vaild = own_rsp_vaild & owner_q;
  assign m0_rsp_err   = own_rsp_err & ~owner_q;
  assign m1_rsp_err   = own_rsp_err & owner_q;

  assign busy    = (state_q != StIdle);
  assign owner   = owner_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: doc/commit_arbiter.md
Name: commit_arbiter

Overview:
- Shares the single req/rsp channel of the `commit` DSP-instruction unit between two instruction sources, for example the host sequencer and a program/replay engine.
- Accepts one 32-bit custom-0 (opcode 0001011) instruction from a requester and forwards it to `commit`.
- Routes the response back to the requester that issued the instruction.
- Enforces one outstanding instruction at a time, round-robin fairness, and a response timeout so a hung `commit` cannot deadlock either source.

Parameters:
- TIMEOUT, default 4096: cycles allowed in WAIT_RSP before an error response is generated; 0 disables the timeout.
- ERRW, default 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock (commit clk domain, clk_150_0)
- reset  in  1  asynchronous, active-low reset
- m0_req_vaild  in  1  requester 0 instruction valid
- m0_req_ready  out  1  requester 0 instruction accepted
- m0_r_in  in  32  requester 0 instruction word
- m0_rsp_vaild  out  1  requester 0 response valid
- m0_rsp_ready  in  1  requester 0 response accept
- m0_rsp_err  out  1  qualifies m0_rsp_vaild; 1 = timeout
- m1_req_vaild, m1_req_ready, m1_r_in, m1_rsp_vaild, m1_rsp_ready, m1_rsp_err: same as m0, for requester 1
- s_req_vaild  out  1  to commit req_vaild
- s_req_ready  in  1  from commit req_ready
- s_r_in  out  32  to commit r_in
- s_rsp_vaild  in  1  from commit rsp_vaild
- s_rsp_ready  out  1  to commit rsp_ready
- busy  out  1  state != IDLE
- owner  out  1  index of the current or last granted requester
- err_cnt  out  ERRW  saturating count of timeouts

Behaviour:
- Reset (reset=0, async): state=IDLE, instr_q=0, owner=0, last=1 (so m0 wins the first tie), timer=0, err_cnt=0.
  - Outputs during reset: s_req_vaild=0, all m*_rsp_vaild/err=0, all m*_req_ready=0.
  - s_rsp_ready=1 during reset (drains stray responses).
  - Reset mid-transaction abandons it silently; no response is delivered.
- States: IDLE, ISSUE, WAIT_RSP, ERR.
- IDLE:
  - Grant selection: if exactly one m*_req_vaild is high, grant it. If both are high, grant ~last.
  - mX_req_ready is combinational: 1 only for the granted X, and only in IDLE.
  - On the mX_req_vaild & mX_req_ready edge: instr_q<=mX_r_in, owner<=X, go to ISSUE.
  - s_rsp_ready=1: stray or late responses are consumed and discarded.
- ISSUE:
  - s_req_vaild=1 and s_r_in=instr_q; both are held stable until s_req_ready.
  - On s_req_ready: go to WAIT_RSP, timer<=0.
  - s_rsp_ready=1 (discard).
  - No timeout in this state.
  - Minimum request latency: grant edge, then 1 cycle in ISSUE.
- WAIT_RSP:
  - Pass-through: m[owner]_rsp_vaild=s_rsp_vaild and s_rsp_ready=m[owner]_rsp_ready. Non-owner outputs are 0. m*_rsp_err=0.
  - On s_rsp_vaild & s_rsp_ready: last<=owner, go to IDLE.
  - Otherwise timer increments.
  - If TIMEOUT!=0 and timer==TIMEOUT-1 with no handshake: go to ERR and increment err_cnt (saturating at all-ones).
  - If the handshake and the timeout occur in the same cycle, the handshake wins: no error.
- ERR:
  - m[owner]_rsp_vaild=1 and m[owner]_rsp_err=1, held until m[owner]_rsp_ready.
  - Then last<=owner, go to IDLE.
  - s_rsp_ready=1: a late commit response is discarded.
- s_r_in is 0 whenever s_req_vaild=0.
- No combinational path from any m*_req_vaild to s_req_vaild.
- owner changes only on a grant.

Test Plan:
- Single source: m0 sends 0x3000600B; commit accepts after 2 cycles and responds after 5 → s_r_in=0x3000600B while s_req_vaild=1, m0_rsp_vaild follows s_rsp_vaild, m0_rsp_err=0, m1 outputs stay 0, busy returns to 0.
- Contention: m0 and m1 both valid in IDLE after reset → m0 granted first and m1 second. Repeat with both valid → m0 then m1 again (strict alternation, owner toggles each transaction).
- Backpressure: s_req_ready held low for 10 cycles → s_req_vaild stays 1 with s_r_in constant. m0_rsp_ready low for 3 cycles during WAIT_RSP → s_rsp_ready low for the same cycles, with no loss.
- Timeout: TIMEOUT=16, commit never responds → after 16 WAIT_RSP cycles m1_rsp_vaild=1 and m1_rsp_err=1, err_cnt=1. A late s_rsp_vaild arriving afterwards is accepted with s_rsp_ready=1 and is not forwarded to either requester.
- Saturation/boundary: ERRW=2 with 5 timeouts → err_cnt=3. Handshake in the exact cycle timer==TIMEOUT-1 → normal response, err_cnt unchanged.
- Reset mid-op: assert reset=0 in WAIT_RSP → all outputs reach their reset values immediately (async). After release, m0 wins a tie.
